// File: rtl/eeprom_mem_arbiter_pkg.sv
// Shared types and sizes for the EEPROM backing-RAM arbiter.
// The state and grant encodings are visible to the parent and to benches.
package eeprom_pkg;

   localparam int EEPROM_ADDR_W = 13;
   localparam int EEPROM_DEPTH  = 8192;

   typedef enum logic [1:0] {
      ARB_INIT,
      ARB_IDLE,
      ARB_ACCESS,
      ARB_DONE
   } arb_state_t;

   typedef enum logic {
      GRANT_EE,
      GRANT_BK
   } grant_t;

endpackage

// File: rtl/eeprom_mem_arbiter.sv
// Shares the single-port EEPROM backing RAM between the I2C engine and the save-backup logic.
// Blank-fills the RAM after reset and tracks whether the engine has modified the save.
module eeprom_mem_arbiter
   import eeprom_pkg::*;
#(
   parameter int               ADDR_W     = EEPROM_ADDR_W,
   parameter int               DATA_W     = 8,
   parameter logic [DATA_W-1:0] FILL_VALUE = 8'hFF,
   parameter bit               INIT_FILL  = 1'b1
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              ee_req,
   input  logic              ee_we,
   input  logic [ADDR_W-1:0] ee_addr,
   input  logic [DATA_W-1:0] ee_wdata,
   output logic              ee_ack,
   output logic [DATA_W-1:0] ee_rdata,
   input  logic              bk_req,
   input  logic              bk_we,
   input  logic [ADDR_W-1:0] bk_addr,
   input  logic [DATA_W-1:0] bk_wdata,
   output logic              bk_ack,
   output logic [DATA_W-1:0] bk_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              init_done,
   output logic              dirty,
   input  logic              dirty_clr
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

   arb_state_t        state;
   grant_t            last_grant;
   grant_t            winner;
   grant_t            next_grant;
   logic              acc_we;
   logic [DATA_W-1:0] ee_rdata_q;
   logic [DATA_W-1:0] bk_rdata_q;

   // Two-way round robin: a contested cycle goes to whoever was not served last.
   always_comb begin
      next_grant = GRANT_BK;
      if (ee_req && bk_req)
         next_grant = (last_grant == GRANT_BK) ? GRANT_EE : GRANT_BK;
      else if (ee_req)
         next_grant = GRANT_EE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= INIT_FILL ? ARB_INIT : ARB_IDLE;
         last_grant <= GRANT_BK;
         winner     <= GRANT_EE;
         acc_we     <= 1'b0;
         mem_addr   <= '0;
         mem_we     <= 1'b0;
         mem_wdata  <= '0;
         ee_ack     <= 1'b0;
         bk_ack     <= 1'b0;
         ee_rdata_q <= '0;
         bk_rdata_q <= '0;
         init_done  <= 1'b0;
         dirty      <= 1'b0;
      end else begin
         ee_ack <= 1'b0;
         bk_ack <= 1'b0;
         if (dirty_clr)
            dirty <= 1'b0;

         case (state)
            ARB_INIT: begin
               // mem_we low marks the first fill cycle; after that mem_addr is the fill counter
               if (!mem_we) begin
                  mem_we    <= 1'b1;
                  mem_addr  <= '0;
                  mem_wdata <= FILL_VALUE;
               end else if (mem_addr == LAST_ADDR) begin
                  mem_we    <= 1'b0;
                  init_done <= 1'b1;
                  state     <= ARB_IDLE;
               end else begin
                  mem_addr <= mem_addr + 1'b1;
               end
            end

            ARB_IDLE: begin
               init_done <= 1'b1;
               mem_we    <= 1'b0;
               if (ee_req || bk_req) begin
                  winner <= next_grant;
                  state  <= ARB_ACCESS;
                  if (next_grant == GRANT_EE) begin
                     mem_addr  <= ee_addr;
                     mem_we    <= ee_we;
                     mem_wdata <= ee_wdata;
                     acc_we    <= ee_we;
                  end else begin
                     mem_addr  <= bk_addr;
                     mem_we    <= bk_we;
                     mem_wdata <= bk_wdata;
                     acc_we    <= bk_we;
                  end
               end
            end

            ARB_ACCESS: begin
               mem_we <= 1'b0;
               if (winner == GRANT_EE)
                  ee_ack <= 1'b1;
               else
                  bk_ack <= 1'b1;
               state <= ARB_DONE;
            end

            ARB_DONE: begin
               if (!acc_we) begin
                  if (winner == GRANT_EE)
                     ee_rdata_q <= mem_rdata;
                  else
                     bk_rdata_q <= mem_rdata;
               end
               // Set after the clear above so a simultaneous set wins
               if (acc_we && winner == GRANT_EE)
                  dirty <= 1'b1;
               last_grant <= winner;
               state      <= ARB_IDLE;
            end

            default: state <= ARB_IDLE;
         endcase
      end
   end

   // RAM data arrives in the DONE cycle, so it is forwarded alongside the ack and held afterwards.
   assign ee_rdata = (ee_ack && !acc_we) ? mem_rdata : ee_rdata_q;
   assign bk_rdata = (bk_ack && !acc_we) ? mem_rdata : bk_rdata_q;

endmodule

// File: tb/tb_eeprom_mem_arbiter.sv
// Bench for eeprom_mem_arbiter: behavioural RAM, shadow-memory scoreboard per port.
module tb_eeprom_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ee_req = 1'b0, ee_we = 1'b0;
   logic [12:0] ee_addr = '0;
   logic [7:0]  ee_wdata = '0;
   logic        ee_ack;
   logic [7:0]  ee_rdata;
   logic        bk_req = 1'b0, bk_we = 1'b0;
   logic [12:0] bk_addr = '0;
   logic [7:0]  bk_wdata = '0;
   logic        bk_ack;
   logic [7:0]  bk_rdata;
   logic [12:0] mem_addr;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        init_done;
   logic        dirty;
   logic        dirty_clr = 1'b0;

   always #5 clk = ~clk;

   eeprom_mem_arbiter dut (
      .clk(clk), .reset(reset),
      .ee_req(ee_req), .ee_we(ee_we), .ee_addr(ee_addr), .ee_wdata(ee_wdata),
      .ee_ack(ee_ack), .ee_rdata(ee_rdata),
      .bk_req(bk_req), .bk_we(bk_we), .bk_addr(bk_addr), .bk_wdata(bk_wdata),
      .bk_ack(bk_ack), .bk_rdata(bk_rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .init_done(init_done), .dirty(dirty), .dirty_clr(dirty_clr)
   );

   logic [7:0] ram [0:8191];
   always_ff @(posedge clk) begin
      if (mem_we)
         ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   typedef struct {
      logic       is_read;
      logic [7:0] data;
   } exp_t;

   exp_t       ee_q[$];
   exp_t       bk_q[$];
   logic [7:0] shadow [0:8191];
   logic [7:0] ee_hold, bk_hold;
   int         checks = 0;
   int         errors = 0;

   function automatic logic [41:0] outs();
      return {ee_ack, bk_ack, ee_rdata, bk_rdata, mem_addr, mem_we, mem_wdata, init_done, dirty};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8192; i++) shadow[i] = 8'hFF;
      ee_hold = 8'h00;
      bk_hold = 8'h00;
      ee_q.delete();
      bk_q.delete();
   endtask

   task automatic push_exp(input logic port_bk, input logic we, input logic [12:0] a,
                           input logic [7:0] d);
      exp_t e;
      e.is_read = !we;
      if (we) begin
         e.data = port_bk ? bk_hold : ee_hold;
         shadow[a] = d;
      end else begin
         e.data = shadow[a];
         if (port_bk) bk_hold = shadow[a];
         else         ee_hold = shadow[a];
      end
      if (port_bk) bk_q.push_back(e);
      else         ee_q.push_back(e);
   endtask

   task automatic xact(input logic e_en, input logic e_w, input logic [12:0] e_a, input logic [7:0] e_d,
                       input logic b_en, input logic b_w, input logic [12:0] b_a, input logic [7:0] b_d,
                       input logic clr_at_ee_ack, output int e_lat, output int b_lat);
      logic e_pend, b_pend;
      exp_t x;
      e_lat = -1;
      b_lat = -1;
      @(negedge clk);
      if (e_en) begin
         ee_req = 1'b1; ee_we = e_w; ee_addr = e_a; ee_wdata = e_d;
         push_exp(1'b0, e_w, e_a, e_d);
      end
      if (b_en) begin
         bk_req = 1'b1; bk_we = b_w; bk_addr = b_a; bk_wdata = b_d;
         push_exp(1'b1, b_w, b_a, b_d);
      end
      e_pend = e_en;
      b_pend = b_en;
      for (int i = 1; i <= 20 && (e_pend || b_pend); i++) begin
         @(negedge clk);
         dirty_clr = 1'b0;
         if (ee_ack) begin
            checks++;
            if (!e_pend || ee_q.size() == 0) begin
               errors++;
               $display("FAIL ee_ack_unexpected: ack at cycle %0d with nothing outstanding", i);
            end else begin
               x = ee_q.pop_front();
               if (ee_rdata !== x.data) begin
                  errors++;
                  $display("FAIL ee_rdata: got %h expected %h", ee_rdata, x.data);
               end
               e_lat = i; e_pend = 1'b0; ee_req = 1'b0;
               if (clr_at_ee_ack) dirty_clr = 1'b1;
            end
         end
         if (bk_ack) begin
            checks++;
            if (!b_pend || bk_q.size() == 0) begin
               errors++;
               $display("FAIL bk_ack_unexpected: ack at cycle %0d with nothing outstanding", i);
            end else begin
               x = bk_q.pop_front();
               if (bk_rdata !== x.data) begin
                  errors++;
                  $display("FAIL bk_rdata: got %h expected %h", bk_rdata, x.data);
               end
               b_lat = i; b_pend = 1'b0; bk_req = 1'b0;
            end
         end
      end
      if (e_en) begin
         checks++;
         if (e_pend) begin errors++; $display("FAIL ee_ack_timeout: got no ack, expected one"); end
      end
      if (b_en) begin
         checks++;
         if (b_pend) begin errors++; $display("FAIL bk_ack_timeout: got no ack, expected one"); end
      end
      ee_req = 1'b0;
      bk_req = 1'b0;
      @(negedge clk);
      dirty_clr = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (outs() !== 42'd0) begin
         errors++;
         $display("FAIL reset_values: got %h expected 0", outs());
      end
   endtask

   task automatic test_fill(input logic hold);
      int we_cnt, bad, last_we, done_at, stray, e_lat, b_lat;
      logic [12:0] nxt;
      exp_t x;
      we_cnt = 0; bad = 0; last_we = -1; done_at = -1; stray = 0; nxt = '0;
      @(negedge clk);
      reset = 1'b0;
      if (hold) begin
         ee_req = 1'b1; ee_we = 1'b0; ee_addr = 13'h0005;
         push_exp(1'b0, 1'b0, 13'h0005, 8'h00);
         bk_req = 1'b1; bk_we = 1'b0; bk_addr = 13'h0006;
         push_exp(1'b1, 1'b0, 13'h0006, 8'h00);
      end
      for (int i = 0; i < 8400 && done_at < 0; i++) begin
         @(negedge clk);
         if (ee_ack || bk_ack) stray++;
         if (init_done) done_at = i;
         else if (mem_we) begin
            if (mem_addr !== nxt || mem_wdata !== 8'hFF) bad++;
            if (last_we >= 0 && i != last_we + 1) bad++;
            nxt++;
            we_cnt++;
            last_we = i;
         end
      end
      checks++;
      if (we_cnt != 8192) begin errors++; $display("FAIL fill_count: got %0d expected 8192", we_cnt); end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL fill_sequence: got %0d bad cycles expected 0", bad); end
      checks++;
      if (done_at != last_we + 1) begin
         errors++;
         $display("FAIL init_done_timing: got cycle %0d expected %0d", done_at, last_we + 1);
      end
      checks++;
      if (stray != 0) begin errors++; $display("FAIL ack_during_init: got %0d acks expected 0", stray); end
      if (hold) begin
         e_lat = -1; b_lat = -1;
         for (int i = 1; i <= 12 && (e_lat < 0 || b_lat < 0); i++) begin
            @(negedge clk);
            if (ee_ack && ee_q.size() != 0) begin
               checks++;
               x = ee_q.pop_front();
               if (ee_rdata !== x.data) begin errors++; $display("FAIL fill_ee_rdata: got %h expected %h", ee_rdata, x.data); end
               e_lat = i; ee_req = 1'b0;
            end
            if (bk_ack && bk_q.size() != 0) begin
               checks++;
               x = bk_q.pop_front();
               if (bk_rdata !== x.data) begin errors++; $display("FAIL fill_bk_rdata: got %h expected %h", bk_rdata, x.data); end
               b_lat = i; bk_req = 1'b0;
            end
         end
         checks++;
         if (e_lat != 2) begin errors++; $display("FAIL first_contention_ee: got %0d expected 2", e_lat); end
         checks++;
         if (b_lat != 5) begin errors++; $display("FAIL first_contention_bk: got %0d expected 5", b_lat); end
         ee_req = 1'b0; bk_req = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_ee_write_read();
      int el, bl;
      xact(1'b1, 1'b1, 13'h0123, 8'h5A, 1'b0, 1'b0, '0, '0, 1'b0, el, bl);
      checks++;
      if (el != 2) begin errors++; $display("FAIL ee_write_latency: got %0d expected 2", el); end
      checks++;
      if (dirty !== 1'b1) begin errors++; $display("FAIL dirty_after_ee_write: got %b expected 1", dirty); end
      xact(1'b1, 1'b0, 13'h0123, 8'h00, 1'b0, 1'b0, '0, '0, 1'b0, el, bl);
      checks++;
      if (el != 2) begin errors++; $display("FAIL ee_read_latency: got %0d expected 2", el); end
   endtask

   task automatic test_back_to_back();
      int ee_got, bk_n, el, bl;
      int bk_c [0:1];
      exp_t x;
      ee_got = -1; bk_n = 0; bk_c[0] = -1; bk_c[1] = -1;
      // last grant was ee, so bk wins; bk holds req for a second access and must yield to ee
      @(negedge clk);
      ee_req = 1'b1; ee_we = 1'b0; ee_addr = 13'h0123;
      push_exp(1'b0, 1'b0, 13'h0123, 8'h00);
      bk_req = 1'b1; bk_we = 1'b0; bk_addr = 13'h0005;
      push_exp(1'b1, 1'b0, 13'h0005, 8'h00);
      for (int i = 1; i <= 20 && (ee_got < 0 || bk_n < 2); i++) begin
         @(negedge clk);
         if (ee_ack && ee_q.size() != 0) begin
            checks++;
            x = ee_q.pop_front();
            if (ee_rdata !== x.data) begin errors++; $display("FAIL b2b_ee_rdata: got %h expected %h", ee_rdata, x.data); end
            ee_got = i; ee_req = 1'b0;
         end
         if (bk_ack && bk_q.size() != 0 && bk_n < 2) begin
            checks++;
            x = bk_q.pop_front();
            if (bk_rdata !== x.data) begin errors++; $display("FAIL b2b_bk_rdata: got %h expected %h", bk_rdata, x.data); end
            bk_c[bk_n] = i;
            bk_n++;
            if (bk_n == 1) begin
               bk_addr = 13'h0123;
               push_exp(1'b1, 1'b0, 13'h0123, 8'h00);
            end else begin
               bk_req = 1'b0;
            end
         end
      end
      checks++;
      if (bk_c[0] != 2) begin errors++; $display("FAIL b2b_bk_first: got %0d expected 2", bk_c[0]); end
      checks++;
      if (ee_got != 5) begin errors++; $display("FAIL b2b_ee_second: got %0d expected 5", ee_got); end
      checks++;
      if (bk_c[1] != 8) begin errors++; $display("FAIL b2b_bk_third: got %0d expected 8", bk_c[1]); end
      ee_req = 1'b0; bk_req = 1'b0;
      @(negedge clk);
      // bk was served last, so a fresh contention goes to ee
      xact(1'b1, 1'b0, 13'h0005, 8'h00, 1'b1, 1'b0, 13'h0123, 8'h00, 1'b0, el, bl);
      checks++;
      if (el != 2) begin errors++; $display("FAIL rr_ee_first: got %0d expected 2", el); end
      checks++;
      if (bl != 5) begin errors++; $display("FAIL rr_bk_second: got %0d expected 5", bl); end
   endtask

   task automatic test_dirty_clr();
      int el, bl;
      @(negedge clk); dirty_clr = 1'b1;
      @(negedge clk); dirty_clr = 1'b0;
      checks++;
      if (dirty !== 1'b0) begin errors++; $display("FAIL dirty_clear_initial: got %b expected 0", dirty); end
      xact(1'b1, 1'b1, 13'h0200, 8'h11, 1'b0, 1'b0, '0, '0, 1'b1, el, bl);
      checks++;
      if (dirty !== 1'b1) begin errors++; $display("FAIL dirty_set_wins: got %b expected 1", dirty); end
      @(negedge clk); dirty_clr = 1'b1;
      @(negedge clk); dirty_clr = 1'b0;
      checks++;
      if (dirty !== 1'b0) begin errors++; $display("FAIL dirty_clear_alone: got %b expected 0", dirty); end
   endtask

   task automatic test_bk_write();
      int el, bl;
      xact(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 13'h1FFF, 8'h33, 1'b0, el, bl);
      checks++;
      if (bl != 2) begin errors++; $display("FAIL bk_write_latency: got %0d expected 2", bl); end
      checks++;
      if (dirty !== 1'b0) begin errors++; $display("FAIL dirty_after_bk_write: got %b expected 0", dirty); end
      checks++;
      if (bk_rdata !== bk_hold) begin errors++; $display("FAIL bk_rdata_hold: got %h expected %h", bk_rdata, bk_hold); end
      xact(1'b1, 1'b0, 13'h1FFF, 8'h00, 1'b0, 1'b0, '0, '0, 1'b0, el, bl);
   endtask

   task automatic test_reset_mid();
      int stray, found, el, bl;
      stray = 0; found = 0;
      @(negedge clk);
      ee_req = 1'b1; ee_we = 1'b1; ee_addr = 13'h0123; ee_wdata = 8'hA5;
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 13'h0123) begin
         errors++;
         $display("FAIL access_setup: got we=%b addr=%h expected we=1 addr=0123", mem_we, mem_addr);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (outs() !== 42'd0) begin errors++; $display("FAIL reset_in_access: got %h expected 0", outs()); end
      repeat (3) begin
         @(negedge clk);
         if (ee_ack || bk_ack) stray++;
      end
      ee_req = 1'b0;
      checks++;
      if (stray != 0) begin errors++; $display("FAIL stray_ack_after_reset: got %0d expected 0", stray); end
      model_reset();
      reset = 1'b0;
      for (int i = 0; i < 4200 && found == 0; i++) begin
         @(negedge clk);
         if (mem_we && mem_addr == 13'd4000) found = 1;
      end
      checks++;
      if (found != 1) begin errors++; $display("FAIL fill_reach_4000: got %0d expected 1", found); end
      reset = 1'b1;
      #1;
      checks++;
      if (outs() !== 42'd0) begin errors++; $display("FAIL reset_in_fill: got %h expected 0", outs()); end
      test_fill(1'b0);
      xact(1'b1, 1'b0, 13'h0123, 8'h00, 1'b0, 1'b0, '0, '0, 1'b0, el, bl);
      checks++;
      if (el != 2) begin errors++; $display("FAIL post_reset_latency: got %0d expected 2", el); end
      checks++;
      if (dirty !== 1'b0) begin errors++; $display("FAIL post_reset_dirty: got %b expected 0", dirty); end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_fill(1'b1);
      test_ee_write_read();
      test_back_to_back();
      test_dirty_clr();
      test_bk_write();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
